sva_stim_gen: RTL and testbench

Stimulus generator and scoreboard for the `test16`-family sequence checkers. It produces the user clock `gclk`, the user reset `grst` and the `a`/`b` input stream from a programmable pattern memory, all from a single `sys_clk`. It also counts the checker's `succ`/`fail`/`lazy_succ` results once per `gclk` period. It is the driving end of the checker interface and sits beside the checker in the bench and FPGA harness.

---
 rtl/sva_stim_gen_if.sv | 21 ++
 rtl/sva_stim_gen.sv | 172 +++++++++++++++++
 tb/tb_sva_stim_gen.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sva_stim_gen_if.sv
// Checker-side signal bundle: generated clock/reset/stimulus out,
// checker results back.
interface sva_stim_gen_if;
    logic gclk;
    logic grst;
    logic a;
    logic b;
    logic succ;
    logic fail;
    logic lazy_succ;

    modport master (
        output gclk, grst, a, b,
        input  succ, fail, lazy_succ
    );

    modport slave (
        input  gclk, grst, a, b,
        output succ, fail, lazy_succ
    );
endinterface

// File: rtl/sva_stim_gen.sv
// Stimulus generator and result scoreboard for sequence checkers.
// Derives gclk/grst/a/b from sys_clk and counts checker results.
module sva_stim_gen #(
    parameter int DIV          = 4,
    parameter int PAT_DEPTH    = 16,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         pat_wr_en,
    input  logic [$clog2(PAT_DEPTH)-1:0] pat_wr_addr,
    input  logic [1:0]                   pat_wr_data,
    input  logic [$clog2(PAT_DEPTH):0]   pat_len,
    input  logic                         start,
    sva_stim_gen_if.master               chk,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             succ_cnt,
    output logic [CNT_W-1:0]             fail_cnt,
    output logic [CNT_W-1:0]             lazy_cnt
);
    localparam int AW   = $clog2(PAT_DEPTH);
    localparam int LW   = AW + 1;
    localparam int PW   = $clog2(2 * DIV);
    localparam int PMAX = (RST_CYCLES > DRAIN_CYCLES) ?
                          RST_CYCLES : DRAIN_CYCLES;
    localparam int CW   = $clog2(PMAX + 1);

    localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_RISE  = PW'(DIV);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] DRN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [LW-1:0] DEPTH    = LW'(PAT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE, S_RESET, S_RUN, S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ph;
    logic [PW-1:0] ph_nxt;
    logic [CW-1:0] pcnt;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [1:0]    mem [PAT_DEPTH];
    logic [1:0]    ab;
    logic          gclk_r;
    logic          grst_r;
    logic          pend;
    logic          skip;
    logic          bnd;
    logic          accept;
    logic          rise;

    assign bnd    = (ph == PH_LAST);
    assign rise   = (ph == PH_RISE);
    assign ph_nxt = bnd ? '0 : ph + PW'(1);

    assign chk.gclk = gclk_r;
    assign chk.grst = grst_r;
    assign chk.a    = ab[0];
    assign chk.b    = ab[1];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (bnd) begin
            unique case (state)
                S_IDLE: begin
                    if (start || pend) begin
                        state_nxt = S_RESET;
                        accept    = 1'b1;
                    end
                end
                S_RESET: begin
                    if (pcnt == RST_LAST)
                        state_nxt = (len == '0) ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    if (idx == len)
                        state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    if (pcnt == DRN_LAST)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Pattern RAM keeps its contents across sys_rst_n.
    always_ff @(posedge sys_clk) begin
        if (pat_wr_en && state == S_IDLE)
            mem[pat_wr_addr] <= pat_wr_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ph     <= '0;
            pcnt   <= '0;
            len    <= '0;
            idx    <= '0;
            ab     <= '0;
            gclk_r <= 1'b0;
            grst_r <= 1'b1;
            pend   <= 1'b0;
            skip   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            ph     <= ph_nxt;
            gclk_r <= (ph_nxt >= PH_RISE);
            grst_r <= (state_nxt == S_IDLE) ||
                      (state_nxt == S_RESET);
            busy   <= (state_nxt != S_IDLE);
            done   <= (state == S_DRAIN) &&
                      (state_nxt == S_IDLE);
            if (accept)
                pend <= 1'b0;
            else if (state == S_IDLE && start)
                pend <= 1'b1;
            if (accept)
                len <= (pat_len > DEPTH) ? DEPTH : pat_len;
            if (state == S_RESET && state_nxt == S_RUN)
                skip <= 1'b1;
            else if (rise && state == S_RUN)
                skip <= 1'b0;
            if (bnd) begin
                pcnt <= (state_nxt != state) ? '0 : pcnt + CW'(1);
                if (state_nxt == S_RUN) begin
                    ab  <= mem[idx[AW-1:0]];
                    idx <= idx + LW'(1);
                end else begin
                    ab  <= '0;
                    idx <= '0;
                end
            end
        end
    end

    // First RUN rising edge carries no checker evaluation yet.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
            lazy_cnt <= '0;
        end else if (accept) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
            lazy_cnt <= '0;
        end else if (rise && !skip &&
                     (state == S_RUN || state == S_DRAIN)) begin
            if (chk.succ && ~&succ_cnt)
                succ_cnt <= succ_cnt + CNT_W'(1);
            if (chk.fail && ~&fail_cnt)
                fail_cnt <= fail_cnt + CNT_W'(1);
            if (chk.lazy_succ && ~&lazy_cnt)
                lazy_cnt <= lazy_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sva_stim_gen.sv
// Directed bench for sva_stim_gen: waveform tables per run offset,
// plus scoring, clamp, ignore-while-busy, reset and saturation cases.
module tb_sva_stim_gen;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        pat_wr_en;
    logic [3:0]  pat_wr_addr;
    logic [1:0]  pat_wr_data;
    logic [4:0]  pat_len;
    logic [4:0]  s_len;
    logic        start;
    logic        s_start;
    logic        busy, done, s_busy, s_done;
    logic [15:0] succ_cnt, fail_cnt, lazy_cnt;
    logic [1:0]  s_succ, s_fail, s_lazy;
    logic        succ_m, lazy_m;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         off;
        logic [5:0] exp;
    } vec_t;

    vec_t dv[14];
    vec_t zv[6];

    logic [5:0]  cap_v [200];
    logic [15:0] cap_s [200];
    logic [15:0] cap_f [200];
    logic [15:0] cap_l [200];

    always #5 sys_clk = ~sys_clk;

    sva_stim_gen_if dif();
    sva_stim_gen_if sif();

    // Checker model: succ when it saw b, lazy_succ when it saw a.
    always @(posedge dif.gclk or posedge dif.grst) begin
        if (dif.grst) begin
            succ_m <= 1'b0;
            lazy_m <= 1'b0;
        end else begin
            succ_m <= dif.b;
            lazy_m <= dif.a;
        end
    end

    assign dif.succ      = succ_m;
    assign dif.fail      = 1'b0;
    assign dif.lazy_succ = lazy_m;
    assign sif.succ      = 1'b0;
    assign sif.fail      = 1'b1;
    assign sif.lazy_succ = 1'b0;

    sva_stim_gen u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pat_wr_en   (pat_wr_en),
        .pat_wr_addr (pat_wr_addr),
        .pat_wr_data (pat_wr_data),
        .pat_len     (pat_len),
        .start       (start),
        .chk         (dif.master),
        .busy        (busy),
        .done        (done),
        .succ_cnt    (succ_cnt),
        .fail_cnt    (fail_cnt),
        .lazy_cnt    (lazy_cnt)
    );

    sva_stim_gen #(.CNT_W(2)) u_sat (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pat_wr_en   (pat_wr_en),
        .pat_wr_addr (pat_wr_addr),
        .pat_wr_data (pat_wr_data),
        .pat_len     (s_len),
        .start       (s_start),
        .chk         (sif.master),
        .busy        (s_busy),
        .done        (s_done),
        .succ_cnt    (s_succ),
        .fail_cnt    (s_fail),
        .lazy_cnt    (s_lazy)
    );

    function automatic logic [5:0] outs();
        return {dif.grst, dif.a, dif.b, dif.gclk, busy, done};
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [1:0] d);
        pat_wr_en   = 1'b1;
        pat_wr_addr = 4'(addr);
        pat_wr_data = d;
        tick();
        pat_wr_en   = 1'b0;
    endtask

    task automatic kick(input int len);
        pat_len = 5'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Offset 0 is the first cycle with busy high.
    // kind 1: start + write pulse at act_off; kind 2: reset at act_off.
    task automatic capture(input int n, input int act_off, input int kind);
        int k = 0;
        while (!busy && k < 40) begin
            tick();
            k++;
        end
        if (!busy) begin
            check("busy_wait", 64'(busy), 64'd1);
            return;
        end
        for (int t = 0; t < n; t++) begin
            if (t > 0)
                tick();
            cap_v[t] = outs();
            cap_s[t] = succ_cnt;
            cap_f[t] = fail_cnt;
            cap_l[t] = lazy_cnt;
            if (kind == 1 && t == act_off) begin
                start       = 1'b1;
                pat_wr_en   = 1'b1;
                pat_wr_addr = 4'd2;
                pat_wr_data = 2'b00;
            end
            if (kind == 1 && t == act_off + 1) begin
                start     = 1'b0;
                pat_wr_en = 1'b0;
            end
            if (kind == 2 && t == act_off) begin
                sys_rst_n = 1'b0;
                #1;
                check("rst_mid_outs", 64'(outs()), 64'b100000);
                check("rst_mid_cnt",
                      64'({succ_cnt, fail_cnt, lazy_cnt}), 64'd0);
                return;
            end
        end
    endtask

    task automatic check_replay(input string tag);
        check({tag, "_a_off24"}, 64'(cap_v[24]), 64'b010010);
        check({tag, "_b_off32"}, 64'(cap_v[32]), 64'b001010);
        check({tag, "_done56"}, 64'(cap_v[56]), 64'b100001);
        check({tag, "_succ"}, 64'(cap_s[56]), 64'd1);
        check({tag, "_lazy"}, 64'(cap_l[56]), 64'd1);
    endtask

    initial begin
        // {grst,a,b,gclk,busy,done} per offset, pattern 00,01,10.
        dv[0]  = '{0,  6'b100010};
        dv[1]  = '{3,  6'b100010};
        dv[2]  = '{4,  6'b100110};
        dv[3]  = '{15, 6'b100110};
        dv[4]  = '{16, 6'b000010};
        dv[5]  = '{20, 6'b000110};
        dv[6]  = '{24, 6'b010010};
        dv[7]  = '{31, 6'b010110};
        dv[8]  = '{32, 6'b001010};
        dv[9]  = '{39, 6'b001110};
        dv[10] = '{40, 6'b000010};
        dv[11] = '{55, 6'b000110};
        dv[12] = '{56, 6'b100001};
        dv[13] = '{57, 6'b100000};
        zv[0]  = '{0,  6'b100010};
        zv[1]  = '{15, 6'b100110};
        zv[2]  = '{16, 6'b000010};
        zv[3]  = '{31, 6'b000110};
        zv[4]  = '{32, 6'b100001};
        zv[5]  = '{33, 6'b100000};

        sys_rst_n   = 1'b0;
        pat_wr_en   = 1'b0;
        pat_wr_addr = '0;
        pat_wr_data = '0;
        pat_len     = '0;
        s_len       = '0;
        start       = 1'b0;
        s_start     = 1'b0;
        #12;
        check("reset_outs", 64'(outs()), 64'b100000);
        check("reset_cnt",
              64'({succ_cnt, fail_cnt, lazy_cnt}), 64'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("gclk_low_3", 64'(dif.gclk), 64'd0);
        tick();
        check("gclk_rise_4", 64'(dif.gclk), 64'd1);

        for (int i = 0; i < 16; i++)
            wr(i, (i < 3) ? 2'(i) : 2'b11);

        kick(3);
        capture(60, -1, 0);
        foreach (dv[i])
            check($sformatf("default_off%0d", dv[i].off),
                  64'(cap_v[dv[i].off]), 64'(dv[i].exp));
        check("score_succ", 64'(cap_s[56]), 64'd1);
        check("score_fail", 64'(cap_f[56]), 64'd0);
        check("score_lazy", 64'(cap_l[56]), 64'd1);

        kick(0);
        capture(36, -1, 0);
        foreach (zv[i])
            check($sformatf("zero_off%0d", zv[i].off),
                  64'(cap_v[zv[i].off]), 64'(zv[i].exp));
        check("zero_cnt",
              64'({cap_s[32], cap_f[32], cap_l[32]}), 64'd0);

        kick(3);
        capture(60, 26, 1);
        check_replay("busy_ign");

        kick(3);
        capture(60, 29, 2);
        check("pre_rst_off29", 64'(cap_v[29]), 64'b010110);
        check("pre_rst_lazy", 64'(cap_l[29]), 64'd1);
        tick();
        sys_rst_n = 1'b1;
        tick();
        kick(3);
        capture(60, -1, 0);
        check_replay("replay");

        kick(20);
        capture(165, -1, 0);
        check("clamp_off159", 64'(cap_v[159]), 64'b000110);
        check("clamp_done160", 64'(cap_v[160]), 64'b100001);

        s_len   = 5'd8;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        begin
            int k = 0;
            while (!s_done && k < 200) begin
                tick();
                k++;
            end
        end
        check("sat_done", 64'({s_done, s_busy}), 64'b10);
        check("sat_fail", 64'(s_fail), 64'd3);
        check("sat_other", 64'({s_succ, s_lazy}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
